// File: rtl/decode_stage.sv
// decode_stage: RV32I decode between fetch and execute.
// Decodes the fetched instruction, reads the register bank and registers
// the operands for execute behind a valid/ready handshake.
// Optional build macro LOAD_USE_STALL_EN: when defined, an instruction that
// reads the destination of a load still held in the output register is
// held back until that load has left (one bubble). When undefined there is
// no interlock and load-use distance is left to software.
module decode_stage #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         if_valid_i,
  output logic                         if_ready_o,
  input  logic [31:0]                  if_instr_i,
  input  logic [31:0]                  if_pc_i,
  output logic                         re_a_o,
  output logic                         re_b_o,
  output logic [$clog2(NUMREGS):0]     raddr_a_o,
  output logic [$clog2(NUMREGS):0]     raddr_b_o,
  input  logic [DATAWIDTH-1:0]         rdata_a_i,
  input  logic [DATAWIDTH-1:0]         rdata_b_i,
  output logic                         ex_valid_o,
  input  logic                         ex_ready_i,
  output logic [31:0]                  ex_pc_o,
  output logic [DATAWIDTH-1:0]         ex_rs1_o,
  output logic [DATAWIDTH-1:0]         ex_rs2_o,
  output logic [DATAWIDTH-1:0]         ex_imm_o,
  output logic [$clog2(NUMREGS):0]     ex_rd_o,
  output logic                         ex_we_o,
  output logic [6:0]                   ex_opcode_o,
  output logic [2:0]                   ex_funct3_o,
  output logic                         ex_funct7b5_o,
  output logic                         ex_is_load_o,
  output logic                         ex_illegal_o
);

  localparam int AW = $clog2(NUMREGS) + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Everything execute sees besides the valid bit.
  typedef struct packed {
    logic [31:0]          pc;
    logic [DATAWIDTH-1:0] rs1;
    logic [DATAWIDTH-1:0] rs2;
    logic [DATAWIDTH-1:0] imm;
    logic [AW-1:0]        rd;
    logic                 we;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic                 is_load;
    logic                 illegal;
  } ex_pkt_t;

  ex_pkt_t     ex_q, ex_d, dec_pkt;
  logic        ex_valid_q, ex_valid_d;
  logic        use_a, use_b, legal, writes, is_load;
  logic [31:0] imm32;
  logic [6:0]  opc;
  logic [31:0] ins;
  logic        adv, stall, xfer;

  assign ins = if_instr_i;
  assign opc = ins[6:0];

  // Opcode classification and immediate formation.
  always_comb begin
    use_a   = 1'b0;
    use_b   = 1'b0;
    legal   = 1'b1;
    writes  = 1'b0;
    is_load = 1'b0;
    imm32   = '0;
    case (opc)
      OP_LUI, OP_AUIPC: begin
        writes = 1'b1;
        imm32  = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        writes = 1'b1;
        imm32  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR: begin
        writes = 1'b1;
        use_a  = 1'b1;
        imm32  = {{20{ins[31]}}, ins[31:20]};
      end
      OP_BRANCH: begin
        use_a = 1'b1;
        use_b = 1'b1;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LOAD: begin
        writes  = 1'b1;
        use_a   = 1'b1;
        is_load = 1'b1;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        use_a = 1'b1;
        use_b = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_OPIMM: begin
        writes = 1'b1;
        use_a  = 1'b1;
        imm32  = {{20{ins[31]}}, ins[31:20]};
      end
      OP_OP: begin
        writes = 1'b1;
        use_a  = 1'b1;
        use_b  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  assign re_a_o    = if_valid_i & use_a;
  assign re_b_o    = if_valid_i & use_b;
  assign raddr_a_o = AW'(ins[19:15]);
  assign raddr_b_o = AW'(ins[24:20]);

  // Packet captured on a transfer; unread operands are zeroed.
  always_comb begin
    dec_pkt          = '0;
    dec_pkt.pc       = if_pc_i;
    dec_pkt.rs1      = re_a_o ? rdata_a_i : '0;
    dec_pkt.rs2      = re_b_o ? rdata_b_i : '0;
    dec_pkt.imm      = DATAWIDTH'($signed(imm32));
    dec_pkt.rd       = AW'(ins[11:7]);
    dec_pkt.we       = writes & (ins[11:7] != 5'd0);
    dec_pkt.opcode   = opc;
    dec_pkt.funct3   = ins[14:12];
    dec_pkt.funct7b5 = ins[30];
    dec_pkt.is_load  = is_load;
    dec_pkt.illegal  = ~legal;
  end

`ifdef LOAD_USE_STALL_EN
  assign stall = ex_valid_q & ex_q.is_load & (ex_q.rd != '0) &
                 (((ex_q.rd == raddr_a_o) & re_a_o) | ((ex_q.rd == raddr_b_o) & re_b_o));
`else
  assign stall = 1'b0;
`endif

  assign adv        = ex_ready_i | ~ex_valid_q;
  assign if_ready_o = adv & ~stall & ~flush_i & ~rst_i;
  assign xfer       = if_valid_i & if_ready_o;

  // Next state: flush kills, advance loads or bubbles, otherwise hold.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (adv) begin
      ex_valid_d = xfer;
      if (xfer) ex_d = dec_pkt;
    end
  end

  // Output register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rd_o       = ex_q.rd;
  assign ex_we_o       = ex_q.we;
  assign ex_opcode_o   = ex_q.opcode;
  assign ex_funct3_o   = ex_q.funct3;
  assign ex_funct7b5_o = ex_q.funct7b5;
  assign ex_is_load_o  = ex_q.is_load;
  assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NUMREGS, default 32: register count; register address ports are $clog2(NUMREGS)+1 bits wide (6 at default).
REQ-002 Parameter DATAWIDTH, default 32: operand/data width; instruction and PC are fixed at 32 bits.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 flush_i  input  1  synchronous kill of the held instruction (branch redirect).
REQ-006 if_valid_i  input  1 / if_ready_o  output  1  fetch-side handshake.
REQ-007 if_instr_i  input  32 / if_pc_i  input  32  fetched instruction and its PC.
REQ-008 re_a_o, re_b_o  output  1  register-bank read enables, ports A/B.
REQ-009 raddr_a_o, raddr_b_o  output  $clog2(NUMREGS)+1  read addresses: rs1 and rs2 fields, zero-extended.
REQ-010 rdata_a_i, rdata_b_i  input  DATAWIDTH  register-bank read data, combinational, write-through.
REQ-011 ex_valid_o  output  1 / ex_ready_i  input  1  execute-side handshake.
REQ-012 ex_pc_o  output  32; ex_rs1_o, ex_rs2_o  output  DATAWIDTH; ex_imm_o  output  DATAWIDTH  registered operands.
REQ-013 ex_rd_o  output  $clog2(NUMREGS)+1; ex_we_o  output  1  destination register and write intent.
REQ-014 ex_opcode_o  output  7; ex_funct3_o  output  3; ex_funct7b5_o  output  1; ex_is_load_o  output  1; ex_illegal_o  output  1.

Function
REQ-015 Decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode SHALL be illegal.
REQ-016 Read enables: rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 used by BRANCH, STORE, OP; re_x_o = if_valid_i & used.
REQ-017 Immediate: I/S/B/U/J format per opcode, sign-extended to DATAWIDTH; B/J bit 0 = 0; U = instr[31:12]<<12; illegal -> 0.
REQ-018 ex_we_o = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP with rd != 0; else 0 (x0 never written).
REQ-019 Output register SHALL advance when ex_ready_i = 1 or ex_valid_o = 0 ("adv").
REQ-020 if_ready_o = adv & ~stall & ~flush_i; a transfer occurs when if_valid_i & if_ready_o; latency one cycle, input to ex_valid_o.
REQ-021 On transfer: capture decoded fields plus rdata_a_i/rdata_b_i (0 when the corresponding read enable is 0); ex_valid_o <= 1.
REQ-022 On adv without transfer: ex_valid_o <= 0 (bubble), other outputs SHALL hold.
REQ-023 If adv = 0 and flush_i = 0, all outputs hold; input not accepted.
REQ-024 flush_i = 1: ex_valid_o <= 0 next cycle, regardless of ex_ready_i; flush has priority over transfer and stall.
REQ-025 Illegal instruction is passed down with ex_illegal_o = 1, ex_we_o = 0, ex_is_load_o = 0.

Reset
REQ-026 While rst_i is high: ex_valid_o, ex_we_o, ex_is_load_o, ex_illegal_o = 0; all other ex_* outputs = 0; if_ready_o = 0.
REQ-027 First transfer possible on the first rising edge after rst_i deasserts; reset mid-transfer discards the instruction.

Configuration
REQ-028 Macro LOAD_USE_STALL_EN defined: stall = ex_valid_o & ex_is_load_o & ex_rd_o != 0 & (ex_rd_o == raddr_a_o & re_a_o | ex_rd_o == raddr_b_o & re_b_o).
REQ-029 Stall blocks acceptance; when the load leaves (ex_ready_i = 1), a bubble is inserted and the dependent instruction transfers the next cycle.
REQ-030 LOAD_USE_STALL_EN undefined: stall = 0 constant; no interlock, software schedules load-use distance.

Verification
REQ-031 ADDI x5,x0,-3 (0xFFD00293), rdata_a_i=0, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFD, ex_rd_o=5, ex_we_o=1.
REQ-032 ex_ready_i=0 with valid instruction held, new if_valid_i=1 -> if_ready_o=0, ex_* stable for 3 cycles; ex_ready_i=1 -> accept.
REQ-033 LW x6,0(x1) then ADD x7,x6,x2, with LOAD_USE_STALL_EN -> exactly one bubble cycle between them; without the macro -> back-to-back.
REQ-034 flush_i=1 with if_valid_i=1, ex_ready_i=0 -> if_ready_o=0, ex_valid_o=0 next cycle.
REQ-035 Opcode 0x7F -> ex_illegal_o=1, ex_we_o=0; ADDI x0,x0,1 -> ex_we_o=0.
REQ-036 Assert rst_i asynchronously mid-stream -> all ex_* outputs read 0 before the next clock edge.
